uart_ip: RTL and testbench
==========================

Name: uart_ip

Overview:
- Register-controlled UART transceiver: 8-bit data, LSB first, one stop bit, optional parity, four selectable baud rates.
- A 32-bit control register (masked write) configures it and launches transmission; a 32-bit status register (masked read) returns received data and flags.
- Contains transmitter instance uart_tnsm_i and a receiver.
- Sits between a simple bus bridge and the serial pins.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive the baud divisors.

Ports:
- clk  in  1  system clock, rising edge
- arst_n  in  1  reset, synchronous, active-low
- ctl_reg_we  in  1  control register write strobe
- ctl_reg_wdata  in  32  control write data
- ctl_reg_wmask  in  32  per-bit write enable
- ctl_reg_rdata  out  32  current control register contents
- st_reg_re  in  1  status read strobe
- st_reg_rmask  in  32  per-bit read mask
- st_reg_rdata  out  32  registered status read data
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output, idle high

Behaviour:
- Everything is clocked on clk. Reset is synchronous active-low on arst_n.
- Reset values:
  - control register = 0x0000_6000
  - st_reg_rdata = 0
  - tx = 1
  - all status flags = 0
  - transmitter idle
- Control register fields:
  - [7:0] tx_data
  - [8] tx_start (write-1 pulse, reads 0)
  - [10:9] baud_sel: 00=9600, 01=19200, 10=57600, 11=115200
  - [11] parity_en
  - [12] parity_odd
  - [13] rx_en
  - [14] tx_en
  - others reserved, read 0
- Control write: when ctl_reg_we=1, each bit i with wmask[i]=1 takes wdata[i] at the next edge. ctl_reg_rdata is combinational from the register.
- Baud tick (tnsm_clk_en):
  - Single-cycle pulse from a free-running divider.
  - Divisor = CLK_FREQ/baud, rounded down: 5208 / 2604 / 868 / 434 at 50 MHz.
  - Divider reloads when baud_sel changes.
- Transmit accept: a write with wmask[8]=1, wdata[8]=1, tx_en=1 and busy=0 latches tx_data. It uses the value being written in the same cycle if wmask[7:0] is set. A start while busy, or while tx_en=0, is ignored.
- Transmitter internal signals (probed by verification; names fixed):
  - busy: 1 from the cycle after accept until the stop bit ends.
  - active: equal to busy.
  - tnsm: start-bit request. Set with busy, cleared on the first tnsm_clk_en.
- Transmitter states:
  - IDLE: tx=1.
  - WAIT_START: tx=1.
  - START: tx=0.
  - DATA: bits 0..7.
  - PARITY: only if parity_en; even, or odd if parity_odd.
  - STOP: tx=1.
- Transmitter transitions:
  - Each transition happens on a tnsm_clk_en, with tx registered. The cycle after the first tick with tnsm&&active, tx=0.
  - At the end of STOP: busy=0, active=0, back to IDLE.
  - Whenever active=0, tx=1.
- Receiver:
  - Enabled by rx_en. rx passes through a 2-flop synchronizer.
  - A falling edge in idle starts a frame.
  - The start bit is re-checked at half a bit period; if high, the frame is aborted (glitch).
  - Bits are then sampled every full bit period, mid-bit.
  - Parity is checked when parity_en; the stop bit must be 1.
  - On stop: rx_data is loaded and rx_valid is set. parity_err / frame_err are set on mismatch.
  - If rx_valid was already 1: overrun is set and the data is overwritten.
- Status register fields:
  - [7:0] rx_data
  - [8] rx_valid
  - [9] tx_busy
  - [10] parity_err
  - [11] frame_err
  - [12] overrun
  - others 0
- Status read:
  - On st_reg_re=1, st_reg_rdata <= status & st_reg_rmask at the next edge; it holds otherwise.
  - If rmask[8]=1 during the read, rx_valid, parity_err, frame_err and overrun clear in the same edge.
  - A receive completion in that same cycle wins: the flags are set.
- Config changes mid-frame take effect from the next frame. The transmitter and receiver latch baud and parity at frame start.
- Reset mid-frame: both engines go to IDLE, tx=1 on the next edge, flags cleared.

Test Plan:
- Reset: after arst_n low then high, ctl_reg_rdata=0x0000_6000, tx=1, st_reg_rdata=0, busy=0.
- TX 9600 8N1:
  - Stimulus: write wdata=0x0000_61A5, mask 0x0000_01FF.
  - tx frame: 0, 1,0,1,0,0,1,0,1, 1.
  - Each bit lasts 5208 clocks; busy=1 throughout, then 0; the frame completes within 1.2 ms.
  - Start-bit check holds: tx=0 the cycle after the first tick.
- Random back-to-back: 100 random bytes, each sent after busy drops.
  - Decoded frames match the bytes.
  - tx=1 whenever active=0.
  - A start issued while busy is ignored.
- Loopback at 115200 with even parity (tx tied to rx), byte 0x3C:
  - rx_valid=1, rx_data=0x3C, parity_err=0.
  - A read with rmask=0xFFFF_FFFF returns 0x13C and then clears rx_valid.
- Error injection:
  - A frame with the stop bit forced 0 sets frame_err.
  - A wrong parity bit sets parity_err.
  - Two frames without a read set overrun.
  - A 1/4-bit low glitch on rx produces no rx_valid.
- Reset mid-frame: assert arst_n during DATA; on the next edge tx=1, busy=0, and no residual frame.

Source files
------------

// File: rtl/uart_ip.sv
// uart_ip: register-controlled 8N1/8P1 UART transceiver.
// TX and RX latch baud and parity at frame start.
package uart_pkg;
   function automatic int unsigned baud_div(int unsigned f, logic [1:0] s);
      int unsigned b;
      case (s)
         2'b00:   b = 9600;
         2'b01:   b = 19200;
         2'b10:   b = 57600;
         default: b = 115200;
      endcase
      return f / b;
   endfunction
endpackage

module uart_tnsm #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       start_i,
   input  logic [7:0] data_i,
   input  logic [1:0] baud_sel_i,
   input  logic [1:0] baud_i,
   input  logic       par_en_i,
   input  logic       par_odd_i,
   output logic       busy,
   output logic       active,
   output logic       tx_o
);
   import uart_pkg::*;
   localparam int CW = $clog2(CLK_FREQ / 9600 + 1);
   typedef enum logic [2:0] {IDLE, WAIT_START, START, DATA, PARITY, STOP} tx_st_e;

   tx_st_e        state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    data_q;
   logic [1:0]    baud_q, sel_q, sel_eff;
   logic          pen_q, podd_q, tx_q, tx_d;
   logic [CW-1:0] cnt_q, last;
   logic          tnsm_clk_en, tnsm, accept;

   assign busy   = state_q != IDLE;
   assign active = busy;
   assign tnsm   = state_q == WAIT_START;
   assign accept = start_i && !busy;
   assign tx_o   = tx_q;

   // divider follows the live register when idle, the latched baud in a frame
   assign sel_eff     = busy ? baud_q : baud_sel_i;
   assign last        = CW'(baud_div(CLK_FREQ, sel_eff) - 1);
   assign tnsm_clk_en = (sel_eff == sel_q) && (cnt_q == last);

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         cnt_q <= '0;
         sel_q <= '0;
      end else begin
         sel_q <= sel_eff;
         if (sel_eff != sel_q || tnsm_clk_en) cnt_q <= '0;
         else cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= IDLE;
         bit_q   <= '0;
         tx_q    <= 1'b1;
         data_q  <= '0;
         baud_q  <= '0;
         pen_q   <= 1'b0;
         podd_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         if (accept) begin
            data_q <= data_i;
            baud_q <= baud_i;
            pen_q  <= par_en_i;
            podd_q <= par_odd_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      unique case (state_q)
         IDLE:       if (accept) state_d = WAIT_START;
         WAIT_START: if (tnsm_clk_en && tnsm && active) state_d = START;
         START: if (tnsm_clk_en) begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: if (tnsm_clk_en) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = pen_q ? PARITY : STOP;
         end
         PARITY: if (tnsm_clk_en) state_d = STOP;
         STOP:   if (tnsm_clk_en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_d = 1'b1;
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_q[bit_d];
         PARITY:  tx_d = ^data_q ^ podd_q;
         default: tx_d = 1'b1;
      endcase
   end
endmodule

module uart_rcv #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       en_i,
   input  logic       rx_i,
   input  logic [1:0] baud_i,
   input  logic       par_en_i,
   input  logic       par_odd_i,
   output logic       done_o,
   output logic [7:0] data_o,
   output logic       perr_o,
   output logic       ferr_o
);
   import uart_pkg::*;
   localparam int CW = $clog2(CLK_FREQ / 9600 + 1);
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_e;

   rx_st_e        state_q, state_d;
   logic [2:0]    sync_q, bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic [1:0]    baud_q;
   logic          pen_q, podd_q, pbit_q, pbit_d, rxs, fall;
   logic [CW-1:0] cnt_q, cnt_d, last, half;

   assign rxs    = sync_q[1];
   assign fall   = sync_q[2] && !sync_q[1];
   assign last   = CW'(baud_div(CLK_FREQ, baud_q) - 1);
   assign half   = last >> 1;
   assign data_o = sh_q;

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         sync_q  <= 3'b111;
         state_q <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         pbit_q  <= 1'b0;
         baud_q  <= '0;
         pen_q   <= 1'b0;
         podd_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], rx_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pbit_q  <= pbit_d;
         if (state_q == R_IDLE) begin
            baud_q <= baud_i;
            pen_q  <= par_en_i;
            podd_q <= par_odd_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pbit_d  = pbit_q;
      unique case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (en_i && fall) state_d = R_START;
         end
         R_START: if (cnt_q == half) begin
            cnt_d   = '0;
            bit_d   = '0;
            state_d = rxs ? R_IDLE : R_DATA;
         end
         R_DATA: if (cnt_q == last) begin
            cnt_d = '0;
            sh_d  = {rxs, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = pen_q ? R_PAR : R_STOP;
         end
         R_PAR: if (cnt_q == last) begin
            cnt_d   = '0;
            pbit_d  = rxs;
            state_d = R_STOP;
         end
         R_STOP: if (cnt_q == last) begin
            cnt_d   = '0;
            state_d = R_IDLE;
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_comb begin
      done_o = (state_q == R_STOP) && (cnt_q == last);
      ferr_o = done_o && !rxs;
      perr_o = done_o && pen_q && (pbit_q != (^sh_q ^ podd_q));
   end
endmodule

module uart_ip #(
   parameter int unsigned CLK_FREQ = 50_000_000
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        ctl_reg_we,
   input  logic [31:0] ctl_reg_wdata,
   input  logic [31:0] ctl_reg_wmask,
   output logic [31:0] ctl_reg_rdata,
   input  logic        st_reg_re,
   input  logic [31:0] st_reg_rmask,
   output logic [31:0] st_reg_rdata,
   input  logic        rx,
   output logic        tx
);
   localparam logic [31:0] CTL_RST = 32'h0000_6000;
   localparam logic [31:0] CTL_RW  = 32'h0000_7EFF;

   logic [31:0] ctl_q, ctl_d, wr_m, st_q, status;
   logic [7:0]  rxd_q, rx_byte;
   logic        start, busy, active, tx_line, clr;
   logic        rx_done, rx_perr, rx_ferr;
   logic        vld_q, perr_q, ferr_q, ovr_q;

   // fields written this cycle are visible to the transmit accept
   assign wr_m  = ctl_reg_we ? ctl_reg_wmask : '0;
   assign ctl_d = ((ctl_q & ~wr_m) | (ctl_reg_wdata & wr_m)) & CTL_RW;
   assign start = ctl_reg_we && ctl_reg_wmask[8] && ctl_reg_wdata[8] && ctl_d[14];
   assign clr   = st_reg_re && st_reg_rmask[8];

   assign status = {19'd0, ovr_q, ferr_q, perr_q, busy, vld_q, rxd_q};
   assign ctl_reg_rdata = ctl_q;
   assign st_reg_rdata  = st_q;
   assign tx = active ? tx_line : 1'b1;

   uart_tnsm #(.CLK_FREQ(CLK_FREQ)) uart_tnsm_i (
      .clk        (clk),
      .arst_n     (arst_n),
      .start_i    (start),
      .data_i     (ctl_d[7:0]),
      .baud_sel_i (ctl_q[10:9]),
      .baud_i     (ctl_d[10:9]),
      .par_en_i   (ctl_d[11]),
      .par_odd_i  (ctl_d[12]),
      .busy       (busy),
      .active     (active),
      .tx_o       (tx_line)
   );

   uart_rcv #(.CLK_FREQ(CLK_FREQ)) uart_rcv_i (
      .clk       (clk),
      .arst_n    (arst_n),
      .en_i      (ctl_q[13]),
      .rx_i      (rx),
      .baud_i    (ctl_q[10:9]),
      .par_en_i  (ctl_q[11]),
      .par_odd_i (ctl_q[12]),
      .done_o    (rx_done),
      .data_o    (rx_byte),
      .perr_o    (rx_perr),
      .ferr_o    (rx_ferr)
   );

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         ctl_q  <= CTL_RST;
         st_q   <= '0;
         rxd_q  <= '0;
         vld_q  <= 1'b0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         ctl_q <= ctl_d;
         if (st_reg_re) st_q <= status & st_reg_rmask;
         if (rx_done) rxd_q <= rx_byte;
         vld_q  <= (vld_q && !clr) || rx_done;
         perr_q <= (perr_q && !clr) || rx_perr;
         ferr_q <= (ferr_q && !clr) || rx_ferr;
         ovr_q  <= (ovr_q && !clr) || (rx_done && vld_q && !clr);
      end
   end
endmodule

// File: tb/tb_uart_ip.sv
// tb_uart_ip: randomized checks of uart_ip against a frame-level model.
// Runs with a reduced CLK_FREQ so every baud rate fits the cycle budget.
module tb_uart_ip;
   localparam int unsigned F = 5_000_000;

   logic        clk = 1'b0;
   logic        arst_n, ctl_reg_we, st_reg_re, rx, tx, rx_drv, loop;
   logic [31:0] ctl_reg_wdata, ctl_reg_wmask, ctl_reg_rdata;
   logic [31:0] st_reg_rmask, st_reg_rdata;
   int          n_chk = 0, n_err = 0, idle_viol = 0;
   bit          mon_en = 1'b0;
   logic [7:0]  m_data = 8'h00;
   bit          m_valid = 0, m_perr = 0, m_ferr = 0, m_ovr = 0;

   always #5 clk = ~clk;
   assign rx = loop ? tx : rx_drv;

   wire t_busy = dut.uart_tnsm_i.busy;
   wire t_act  = dut.uart_tnsm_i.active;
   wire t_tnsm = dut.uart_tnsm_i.tnsm;
   wire t_tick = dut.uart_tnsm_i.tnsm_clk_en;

   uart_ip #(.CLK_FREQ(F)) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .ctl_reg_we    (ctl_reg_we),
      .ctl_reg_wdata (ctl_reg_wdata),
      .ctl_reg_wmask (ctl_reg_wmask),
      .ctl_reg_rdata (ctl_reg_rdata),
      .st_reg_re     (st_reg_re),
      .st_reg_rmask  (st_reg_rmask),
      .st_reg_rdata  (st_reg_rdata),
      .rx            (rx),
      .tx            (tx)
   );

   always @(negedge clk)
      if (mon_en && !t_act && tx !== 1'b1) idle_viol++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int div_of(input int sel);
      case (sel)
         0:       return int'(F / 9600);
         1:       return int'(F / 19200);
         2:       return int'(F / 57600);
         default: return int'(F / 115200);
      endcase
   endfunction

   // serial frame: start, 8 data bits LSB first, optional parity, stop
   function automatic logic [10:0] frame_bits(input logic [7:0] d,
                                              input bit pen, input bit podd);
      logic [10:0] b;
      b = '1;
      b[0] = 1'b0;
      for (int i = 0; i < 8; i++) b[i+1] = d[i];
      if (pen) b[9] = (($countones(d) % 2) == 1) ^ podd;
      return b;
   endfunction

   function automatic logic [31:0] cfg(input bit ten, input bit pen,
      input bit podd, input int sel, input bit st, input logic [7:0] d);
      logic [1:0] s;
      s = 2'(sel);
      return {17'd0, ten, 1'b1, podd, pen, s, st, d};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ctl_wr(input logic [31:0] d, input logic [31:0] m);
      ctl_reg_we = 1'b1;
      ctl_reg_wdata = d;
      ctl_reg_wmask = m;
      @(negedge clk);
      ctl_reg_we = 1'b0;
      ctl_reg_wmask = '0;
   endtask

   task automatic st_rd(input logic [31:0] m, output logic [31:0] v);
      st_reg_re = 1'b1;
      st_reg_rmask = m;
      @(negedge clk);
      st_reg_re = 1'b0;
      v = st_reg_rdata;
   endtask

   task automatic tx_send(input logic [31:0] d32, input logic [31:0] m32,
      input logic [7:0] d, input int sel, input bit pen, input bit podd,
      input bit poke, output int used);
      int dv, nb, t, bl;
      bit seen, prev_tick;
      logic [10:0] b;
      logic first;
      dv = div_of(sel);
      nb = pen ? 11 : 10;
      b = frame_bits(d, pen, podd);
      first = 1'b1;
      ctl_wr(d32, m32);
      chk("busy_accept", t_busy, 1);
      seen = 0;
      prev_tick = 0;
      t = 0;
      while (!seen && t < 2 * dv + 8) begin
         if (tx === 1'b0) seen = 1;
         else begin
            prev_tick = t_tick && t_tnsm;
            @(negedge clk);
            t++;
         end
      end
      chk("start_seen", seen, 1);
      if (!seen) begin
         used = t;
         return;
      end
      chk("start_tick", prev_tick, 1);
      bl = 0;
      for (int c = 0; c < nb * dv; c++) begin
         if (c % dv == 0) first = tx;
         if (c % dv == dv - 1)
            chk("tx_bit", {30'd0, first, tx}, {30'd0, b[c/dv], b[c/dv]});
         if (!t_busy) bl++;
         if (poke && c == 3 * dv + 5) begin
            ctl_reg_we = 1'b1;
            ctl_reg_wdata = cfg(1, pen, podd, sel, 1, ~d);
            ctl_reg_wmask = 32'h7FFF;
         end
         if (poke && c == 3 * dv + 6) ctl_reg_we = 1'b0;
         @(negedge clk);
      end
      chk("busy_frame", bl, 0);
      chk("busy_end", t_busy, 0);
      used = 1 + t + nb * dv;
      if (poke) begin
         bl = 0;
         for (int c = 0; c < 2 * dv; c++) begin
            if (t_busy || tx !== 1'b1) bl++;
            @(negedge clk);
         end
         chk("ignored_start", bl, 0);
      end
   endtask

   task automatic rx_send(input logic [7:0] d, input bit pen, input bit podd,
                          input bit bad_par, input bit bad_stop);
      int dv, nb;
      logic [10:0] b;
      dv = div_of(3);
      nb = pen ? 11 : 10;
      b = frame_bits(d, pen, podd);
      if (bad_par) b[9] = ~b[9];
      if (bad_stop) b[nb-1] = 1'b0;
      for (int k = 0; k < nb; k++) begin
         rx_drv = b[k];
         cyc(dv);
      end
      rx_drv = 1'b1;
      cyc(dv);
      if (m_valid) m_ovr = 1;
      m_valid = 1;
      m_data = d;
      if (bad_par) m_perr = 1;
      if (bad_stop) m_ferr = 1;
   endtask

   task automatic rd_model(input string tag);
      logic [31:0] v;
      st_rd(32'hFFFF_FFFF, v);
      chk(tag, v, {19'd0, m_ovr, m_ferr, m_perr, 1'b0, m_valid, m_data});
      m_valid = 0;
      m_perr = 0;
      m_ferr = 0;
      m_ovr = 0;
   endtask

   initial begin
      logic [31:0] v;
      logic [7:0] d;
      int used, lows;
      bit pen, podd;
      arst_n = 1'b0;
      ctl_reg_we = 1'b0;
      ctl_reg_wdata = '0;
      ctl_reg_wmask = '0;
      st_reg_re = 1'b0;
      st_reg_rmask = '0;
      rx_drv = 1'b1;
      loop = 1'b0;
      cyc(4);
      arst_n = 1'b1;
      chk("rst_ctl", ctl_reg_rdata, 32'h0000_6000);
      chk("rst_tx", tx, 1);
      chk("rst_st", st_reg_rdata, 0);
      chk("rst_busy", t_busy, 0);
      mon_en = 1'b1;

      tx_send(32'h0000_61A5, 32'h0000_01FF, 8'hA5, 0, 0, 0, 0, used);
      chk("frame_1p2ms", used <= int'(F / 1000 * 12 / 10), 1);
      chk("ctl_after_wr", ctl_reg_rdata, 32'h0000_60A5);

      ctl_wr(cfg(0, 0, 0, 3, 1, 8'h5A), 32'h7FFF);
      lows = 0;
      for (int c = 0; c < 2 * div_of(3); c++) begin
         if (t_busy || tx !== 1'b1) lows++;
         @(negedge clk);
      end
      chk("tx_en_off", lows, 0);

      for (int i = 0; i < 100; i++) begin
         d = 8'($urandom);
         pen = 1'($urandom);
         podd = 1'($urandom);
         tx_send(cfg(1, pen, podd, 3, 1, d), 32'h7FFF, d, 3, pen, podd,
                 (i % 10) == 3, used);
      end

      loop = 1'b1;
      tx_send(cfg(1, 1, 0, 3, 1, 8'h3C), 32'h7FFF, 8'h3C, 3, 1, 0, 0, used);
      cyc(4);
      loop = 1'b0;
      st_rd(32'h0000_FEFF, v);
      chk("lb_peek", v, 32'h0000_003C);
      st_rd(32'hFFFF_FFFF, v);
      chk("lb_read", v, 32'h0000_013C);
      cyc(2);
      chk("st_hold", st_reg_rdata, 32'h0000_013C);
      st_rd(32'hFFFF_FFFF, v);
      chk("lb_cleared", v, 32'h0000_003C);
      m_data = 8'h3C;

      ctl_wr(cfg(1, 1, 0, 3, 0, 8'h00), 32'h7E00);
      rx_send(8'($urandom), 1, 0, 0, 1);
      rd_model("rx_ferr");
      rx_send(8'($urandom), 1, 0, 1, 0);
      rd_model("rx_perr");
      rx_send(8'($urandom), 1, 0, 0, 0);
      rx_send(8'($urandom), 1, 0, 0, 0);
      rd_model("rx_ovr");
      rx_drv = 1'b0;
      cyc(div_of(3) / 4);
      rx_drv = 1'b1;
      cyc(2 * div_of(3));
      rd_model("rx_glitch");
      for (int i = 0; i < 6; i++) begin
         pen = 1'($urandom);
         podd = 1'($urandom);
         ctl_wr(cfg(1, pen, podd, 3, 0, 8'h00), 32'h7E00);
         rx_send(8'($urandom), pen, podd, 0, 0);
         rd_model("rx_rand");
      end

      ctl_wr(cfg(1, 0, 0, 0, 1, 8'h00), 32'h7FFF);
      lows = 0;
      while (tx !== 1'b0 && lows < 2 * div_of(0)) begin
         @(negedge clk);
         lows++;
      end
      chk("mid_start", tx, 0);
      cyc(3 * div_of(0));
      arst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", t_busy, 0);
      arst_n = 1'b1;
      lows = 0;
      for (int c = 0; c < 2 * div_of(0); c++) begin
         if (t_busy || tx !== 1'b1) lows++;
         @(negedge clk);
      end
      chk("no_residual", lows, 0);
      chk("mid_rst_ctl", ctl_reg_rdata, 32'h0000_6000);
      chk("mid_rst_st", st_reg_rdata, 0);
      chk("tx_idle_high", idle_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
